// File: rtl/iir_serial_mac_sched.sv
// Direct-form-I IIR filter controller sharing one signed multiplier and one
// accumulator across all b/a taps, with its own coefficient file and x/y history.
module iir_serial_mac_sched #(
    parameter int ORDER = 9,
    parameter int W     = 64,
    parameter int FRAC  = 52,
    parameter int ACC_W = 2*W+8,
    parameter int AW    = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_t;

    localparam int NT = 2*ORDER+1;
    localparam logic [AW-1:0] LAST_IDX = AW'(2*ORDER);
    localparam logic [AW-1:0] LAST_B   = AW'(ORDER);

    state_t state, state_nxt;

    // coef[0..N] = b0..bN, coef[N+1..2N] = a1..aN; x_hist[0]/y_hist[0] hold x1/y1
    logic signed [W-1:0]     coef   [NT];
    logic signed [W-1:0]     x_hist [ORDER];
    logic signed [W-1:0]     y_hist [ORDER];
    logic signed [W-1:0]     xin;
    logic signed [ACC_W-1:0] acc;
    logic [AW-1:0]           idx;

    logic signed [W-1:0]     coef_sel, samp_sel;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] rnd;
    logic signed [W-1:0]     sat_val;
    logic                    cfg_ok;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign cfg_ok   = (state == IDLE) && (cfg_addr <= LAST_IDX);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = MAC;
            MAC:  if (idx == LAST_IDX) state_nxt = RND;
            RND:  state_nxt = OUT;
            OUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand select for the shared multiplier, keyed on the tap index
    always_comb begin
        coef_sel = '0;
        samp_sel = '0;
        for (int unsigned k = 0; k < NT; k++)
            if (idx == AW'(k)) coef_sel = coef[k];
        if (idx == '0) samp_sel = xin;
        for (int unsigned k = 0; k < ORDER; k++) begin
            if (idx == AW'(k+1))       samp_sel = x_hist[k];
            if (idx == AW'(k+ORDER+1)) samp_sel = y_hist[k];
        end
    end

    assign prod     = coef_sel * samp_sel;
    assign prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};

    // Floor-shift to sample scale, then clamp to the W-bit signed range
    always_comb begin
        rnd = acc >>> FRAC;
        if ((&rnd[ACC_W-1:W-1]) || !(|rnd[ACC_W-1:W-1]))
            sat_val = rnd[W-1:0];
        else if (rnd[ACC_W-1])
            sat_val = {1'b1, {(W-1){1'b0}}};
        else
            sat_val = {1'b0, {(W-1){1'b1}}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < NT; k++) coef[k] <= '0;
            for (int unsigned k = 0; k < ORDER; k++) begin
                x_hist[k] <= '0;
                y_hist[k] <= '0;
            end
            xin       <= '0;
            acc       <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok)
                for (int unsigned k = 0; k < NT; k++)
                    if (cfg_addr == AW'(k)) coef[k] <= cfg_data;

            case (state)
                IDLE: if (in_valid) begin
                    xin <= in_data;
                    acc <= '0;
                    idx <= '0;
                end
                MAC: begin
                    if (idx > LAST_B) acc <= acc - prod_ext;
                    else              acc <= acc + prod_ext;
                    idx <= idx + 1'b1;
                end
                RND: begin
                    out_data  <= sat_val;
                    out_valid <= 1'b1;
                    x_hist[0] <= xin;
                    y_hist[0] <= sat_val;
                    for (int unsigned k = 1; k < ORDER; k++) begin
                        x_hist[k] <= x_hist[k-1];
                        y_hist[k] <= y_hist[k-1];
                    end
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/iir_serial_mac_sched.md
Name: iir_serial_mac_sched

Overview:
Time-multiplexed controller for a direct-form-I IIR filter of order ORDER. It shares one signed W×W multiplier and one accumulator across all b/a taps. The block accepts one input sample per valid/ready handshake and sequences 2*ORDER+1 multiply-accumulates, then rounds, saturates and emits y[n]. It owns the coefficient register file, written through a config port, and the x/y history. It replaces the fully parallel filter wherever area matters more than throughput.

Parameters:
ORDER, 9, filter order N (taps b0..bN, a1..aN)
W, 64, sample and coefficient width, signed two's complement
FRAC, 52, fractional bits of samples and coefficients (1.0 = 2^FRAC)
ACC_W, 2*W+8, accumulator width (guard bits for 2N+1 products)
AW, 5, config address width, must satisfy 2^AW > 2*ORDER

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
cfg_we  in  1  coefficient write strobe
cfg_addr  in  AW  0..N selects b0..bN; N+1..2N selects a1..aN
cfg_data  in  W  coefficient value
cfg_err  out  1  one-cycle pulse on a rejected write
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_data  in  W  x[n]
out_valid  out  1  y[n] valid
out_ready  in  1  downstream accepts y[n]
out_data  out  W  y[n]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All coefficients, x history x1..xN, y history y1..yN, acc, out_data, out_valid and cfg_err cleared to 0. Reset mid-computation aborts it with no output.
- States:
  - IDLE: in_ready=1. On in_valid: latch xin=in_data, acc=0, idx=0, go to MAC.
  - MAC: one product per cycle.
    - idx 0: acc += b0*xin.
    - idx 1..N: acc += b[idx]*x[idx].
    - idx N+1..2N: acc -= a[idx-N]*y[idx-N].
    - idx increments each cycle; after idx=2N, go to RND.
  - RND: r = acc >>> FRAC (arithmetic shift, truncation toward −inf). Saturate r to [−2^(W−1), 2^(W−1)−1] and write it to out_data. Shift histories: x1<=xin, xk<=x(k−1); y1<=saturated r, yk<=y(k−1). Set out_valid=1 and go to OUT.
  - OUT: out_valid and out_data held stable until out_ready=1. On that edge: out_valid=0, go to IDLE.
- in_ready=0 outside IDLE. Input is never accepted while a result is pending.
- Latency:
  - out_valid rises on the edge 2N+2 clocks after the acceptance edge, which is 20 with defaults.
  - Minimum sample period with out_ready held high is 2N+4 clocks (22).
- Products are full 2W signed, sign-extended to ACC_W. Accumulator wrap is impossible within ACC_W.
- Config writes:
  - Accepted only when state=IDLE and cfg_addr<=2N; the register updates on that edge.
  - cfg_we in any other state, or with cfg_addr>2N, leaves registers unchanged and pulses cfg_err for one cycle.
  - cfg_we and an in_valid acceptance in the same IDLE cycle: both take effect. MAC reads coefficients from the following cycle, so the new value is used.
- History persists across samples. It is cleared only by reset; coefficient writes do not clear it.

Test Plan:
- Reset: after reset, in_ready=1, out_valid=0, busy=0, cfg_err=0, out_data=0; one sample with all coefficients 0 -> out_data=0.
- Identity filter: b0=0x0010000000000000, all others 0; in_data=0x0030000000000000 (3.0) -> out_valid exactly 20 clocks after acceptance, out_data=0x0030000000000000.
- Single pole: b0=0x0008000000000000 (0.5), a1=0xFFF8000000000000 (−0.5); impulse 1.0 then zeros -> outputs 0x0008000000000000, 0x0004000000000000, 0x0002000000000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, busy=1; release -> returns to IDLE next edge; a back-to-back sample completes 22 clocks apart.
- Saturation: b0=0x7FFFFFFFFFFFFFFF, in_data=0x7FFFFFFFFFFFFFFF -> out_data=0x7FFFFFFFFFFFFFFF. Negated input -> 0x8000000000000000.
- Config errors: cfg_we during MAC, or cfg_addr=19 in IDLE -> one-cycle cfg_err, coefficient unchanged (verified by rerunning the identity test). Reset asserted mid-MAC -> no out_valid, all state 0.
